nios_mutex_bank: RTL and testbench

- Parametrised bank of NUM_MUTEX hardware mutexes behind one Avalon-MM slave, for multi-CPU Nios systems.
- Each mutex holds an OWNER_W-bit owner ID and a VALUE_W-bit value, plus a status word.
- Adds an optional lease timeout that auto-releases a mutex whose holder stops refreshing it.
- Adds a compile-time release interrupt.

---
 rtl/nios_mutex_bank.sv | 180 ++++++++++++++++++
 tb/tb_nios_mutex_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_mutex_bank.sv
// Bank of NUM_MUTEX Avalon-MM hardware mutexes with an optional lease timeout (TIMEOUT>0).
// Define MUTEX_IRQ_EN to build per-mutex release-pending/irq-enable flags and the irq output.
module nios_mutex_bank #(
  parameter int NUM_MUTEX = 4,
  parameter int OWNER_W   = 16,
  parameter int VALUE_W   = 16,
  parameter int TIMEOUT   = 0,
  parameter int ADDR_W    = ((NUM_MUTEX > 1) ? $clog2(NUM_MUTEX) : 1) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write,
  input  logic              read,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata
`ifdef MUTEX_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [IDX_W-1:0]   idx;
  logic               wr_m, wr_s;
  logic [OWNER_W-1:0] wr_owner;
  logic [VALUE_W-1:0] wr_value;
  logic               unused_wd;

  assign idx       = address[ADDR_W-1:1];
  assign wr_m      = chipselect & write & ~address[0];
  assign wr_s      = chipselect & write & address[0];
  assign wr_owner  = writedata[16 +: OWNER_W];
  assign wr_value  = writedata[0 +: VALUE_W];
  assign unused_wd = ^writedata;

  logic [OWNER_W-1:0] owner_q [NUM_MUTEX];
  logic [OWNER_W-1:0] owner_d [NUM_MUTEX];
  logic [VALUE_W-1:0] value_q [NUM_MUTEX];
  logic [VALUE_W-1:0] value_d [NUM_MUTEX];
  logic [NUM_MUTEX-1:0] tmo_q, tmo_d;
  logic                 init_q, init_d;
  logic [NUM_MUTEX-1:0] acc, sel_s, expire;

  // Out-of-range indices match no mutex, so their writes fall away naturally.
  always_comb begin
    acc   = '0;
    sel_s = '0;
    for (int i = 0; i < NUM_MUTEX; i++) begin
      if (idx == IDX_W'(i)) begin
        acc[i]   = wr_m && (value_q[i] == '0 || owner_q[i] == wr_owner);
        sel_s[i] = wr_s;
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_lease
      logic [CNT_W-1:0] cnt_q [NUM_MUTEX];
      logic [CNT_W-1:0] cnt_d [NUM_MUTEX];

      always_comb begin
        expire = '0;
        for (int i = 0; i < NUM_MUTEX; i++) begin
          cnt_d[i]  = cnt_q[i];
          expire[i] = (value_q[i] != '0) && (cnt_q[i] == '0);
          if (acc[i] && wr_value != '0) begin
            cnt_d[i] = CNT_W'(TIMEOUT - 1);
          end else if (value_q[i] != '0 && cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < NUM_MUTEX; i++) cnt_q[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_MUTEX; i++) cnt_q[i] <= cnt_d[i];
        end
      end
    end else begin : g_no_lease
      assign expire = '0;
    end
  endgenerate

  // An accepted write on the expiry cycle wins; a hardware set beats a same-cycle W1C.
  always_comb begin
    init_d = init_q;
    tmo_d  = tmo_q;
    for (int i = 0; i < NUM_MUTEX; i++) begin
      owner_d[i] = owner_q[i];
      value_d[i] = value_q[i];
      if (acc[i]) begin
        owner_d[i] = wr_owner;
        value_d[i] = wr_value;
      end else if (expire[i]) begin
        value_d[i] = '0;
      end
      if (sel_s[i] && writedata[1]) tmo_d[i] = 1'b0;
      if (expire[i] && !acc[i])     tmo_d[i] = 1'b1;
      if (sel_s[i] && writedata[0]) init_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_q <= 1'b1;
      tmo_q  <= '0;
      for (int i = 0; i < NUM_MUTEX; i++) begin
        owner_q[i] <= '0;
        value_q[i] <= '0;
      end
    end else begin
      init_q <= init_d;
      tmo_q  <= tmo_d;
      for (int i = 0; i < NUM_MUTEX; i++) begin
        owner_q[i] <= owner_d[i];
        value_q[i] <= value_d[i];
      end
    end
  end

`ifdef MUTEX_IRQ_EN
  logic [NUM_MUTEX-1:0] rel_q, rel_d, ien_q, ien_d;
  logic                 irq_q, irq_d;

  always_comb begin
    rel_d = rel_q;
    ien_d = ien_q;
    for (int i = 0; i < NUM_MUTEX; i++) begin
      if (sel_s[i]) begin
        if (writedata[2]) rel_d[i] = 1'b0;
        ien_d[i] = writedata[3];
      end
      if (value_q[i] != '0 && value_d[i] == '0) rel_d[i] = 1'b1;
    end
    irq_d = |(rel_q & ien_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rel_q <= '0;
      ien_q <= '0;
      irq_q <= 1'b0;
    end else begin
      rel_q <= rel_d;
      ien_q <= ien_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    readdata = '0;
    if (chipselect && read) begin
      for (int i = 0; i < NUM_MUTEX; i++) begin
        if (idx == IDX_W'(i)) begin
          if (address[0]) begin
            readdata[0] = init_q;
            readdata[1] = tmo_q[i];
`ifdef MUTEX_IRQ_EN
            readdata[2] = rel_q[i];
            readdata[3] = ien_q[i];
`endif
          end else begin
            readdata[16 +: OWNER_W] = owner_q[i];
            readdata[0 +: VALUE_W]  = value_q[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_nios_mutex_bank.sv
// Scoreboard bench: dut 0 is the default bank (4 mutexes, no lease), dut 1 has 3 mutexes and TIMEOUT=8.
module tb_nios_mutex_bank;

  typedef struct {
    int          d;
    string       nm;
    logic [31:0] rd;
    bit          ci;
    bit          irq;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cs, we, re;
  logic [2:0]  addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        irq_a, unused_irq_b;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nios_mutex_bank u_a (
    .clk(clk), .reset(rst), .address(addr[0]), .chipselect(cs[0]), .write(we[0]),
    .read(re[0]), .writedata(wd[0]), .readdata(rdata[0])
`ifdef MUTEX_IRQ_EN
    , .irq(irq_a)
`endif
  );

  nios_mutex_bank #(.NUM_MUTEX(3), .TIMEOUT(8)) u_b (
    .clk(clk), .reset(rst), .address(addr[1]), .chipselect(cs[1]), .write(we[1]),
    .read(re[1]), .writedata(wd[1]), .readdata(rdata[1])
`ifdef MUTEX_IRQ_EN
    , .irq(unused_irq_b)
`endif
  );

`ifndef MUTEX_IRQ_EN
  assign irq_a        = 1'b0;
  assign unused_irq_b = 1'b0;
`endif

  // Monitor: whenever a read is presented, pop the next expectation and compare.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cs[d] && re[d]) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read dut%0d got %08h with empty scoreboard", d, rdata[d]);
        end else begin
          cur = sb.pop_front();
          checks++;
          if (cur.d != d || rdata[d] !== cur.rd) begin
            errors++;
            $display("FAIL %s dut%0d got %08h expected %08h", cur.nm, d, rdata[d], cur.rd);
          end
          if (cur.ci) begin
            checks++;
            if (irq_a !== cur.irq) begin
              errors++;
              $display("FAIL %s_irq got %0b expected %0b", cur.nm, irq_a, cur.irq);
            end
          end
        end
      end
    end
  end

  task automatic wr(input int d, input logic [2:0] a, input logic [31:0] v);
    cs[d] = 1'b1; we[d] = 1'b1; addr[d] = a; wd[d] = v;
    @(posedge clk); #1;
    cs[d] = 1'b0; we[d] = 1'b0; wd[d] = '0;
  endtask

  task automatic rd(input int d, input logic [2:0] a, input logic [31:0] e, input string nm,
                    input bit ci = 1'b0, input bit ei = 1'b0);
    exp_t x;
    x.d = d; x.nm = nm; x.rd = e; x.ci = ci; x.irq = ei;
    sb.push_back(x);
    cs[d] = 1'b1; re[d] = 1'b1; addr[d] = a;
    @(posedge clk); #1;
    cs[d] = 1'b0; re[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cs = '0; we = '0; re = '0; rst = 1'b1;
    for (int d = 0; d < 2; d++) begin addr[d] = '0; wd[d] = '0; end
    idle(3);
    rst = 1'b0;
    idle(1);

    // Reset state and init clear
    rd(0, 3'd3, 32'h1, "rst_status1");
    rd(1, 3'd1, 32'h1, "rst_status0_b");
    wr(0, 3'd3, 32'h1);
    rd(0, 3'd3, 32'h0, "init_cleared");
    rd(0, 3'd0, 32'h0, "rst_mutex0");

    // Acquire / reject / release / re-acquire on mutex 2
    wr(0, 3'd4, 32'h0005_0001);
    rd(0, 3'd4, 32'h0005_0001, "acquire");
    wr(0, 3'd4, 32'h0007_0003);
    rd(0, 3'd4, 32'h0005_0001, "reject_other_owner");
    wr(0, 3'd4, 32'h0005_0000);
    rd(0, 3'd4, 32'h0005_0000, "release");
    wr(0, 3'd4, 32'h0007_0003);
    rd(0, 3'd4, 32'h0007_0003, "reacquire");

    // Lease expiry: value clears at the 8th edge after the write edge
    wr(1, 3'd2, 32'h0002_0009);
    idle(6);
    rd(1, 3'd2, 32'h0002_0009, "lease_e7");
    rd(1, 3'd2, 32'h0002_0009, "lease_e8_last");
    rd(1, 3'd2, 32'h0002_0000, "lease_expired");
    rd(1, 3'd3, 32'h3, "timeout_set");
    wr(1, 3'd3, 32'h2);
    rd(1, 3'd3, 32'h1, "timeout_w1c");

    // Refresh at cycle 5 postpones the expiry by a full lease
    wr(1, 3'd0, 32'h0002_0009);
    idle(4);
    wr(1, 3'd0, 32'h0002_0009);
    idle(7);
    rd(1, 3'd0, 32'h0002_0009, "refresh_held");
    rd(1, 3'd0, 32'h0002_0000, "refresh_expired");
    rd(1, 3'd1, 32'h3, "refresh_timeout");

    // Accepted write on the expiry cycle wins
    wr(1, 3'd4, 32'h0003_0001);
    idle(7);
    wr(1, 3'd4, 32'h0003_0005);
    rd(1, 3'd4, 32'h0003_0005, "write_beats_expiry");
    rd(1, 3'd5, 32'h1, "no_timeout_on_win");

    // W1C on the same edge as a timeout set leaves the bit set
    wr(1, 3'd1, 32'h2);
    rd(1, 3'd1, 32'h1, "pre_w1c_clear");
    wr(1, 3'd0, 32'h0002_0009);
    idle(7);
    wr(1, 3'd1, 32'h2);
    rd(1, 3'd1, 32'h3, "set_beats_w1c");
    rd(1, 3'd0, 32'h0002_0000, "set_beats_w1c_val");

`ifdef MUTEX_IRQ_EN
    wr(0, 3'd7, 32'h8);
    wr(0, 3'd6, 32'h0001_0001);
    wr(0, 3'd6, 32'h0001_0000);
    rd(0, 3'd7, 32'hC, "irq_rel_e1", 1'b1, 1'b0);
    rd(0, 3'd7, 32'hC, "irq_rise", 1'b1, 1'b1);
    wr(0, 3'd7, 32'h4);
    rd(0, 3'd7, 32'h0, "irq_clr_e3", 1'b1, 1'b1);
    rd(0, 3'd7, 32'h0, "irq_fall", 1'b1, 1'b0);
    wr(0, 3'd6, 32'h0001_0002);
    wr(0, 3'd6, 32'h0001_0000);
    rd(0, 3'd7, 32'h4, "rel_no_en", 1'b1, 1'b0);
    rd(0, 3'd7, 32'h4, "rel_no_en_hold", 1'b1, 1'b0);
`else
    wr(0, 3'd7, 32'hC);
    wr(0, 3'd6, 32'h0001_0001);
    wr(0, 3'd6, 32'h0001_0000);
    rd(0, 3'd7, 32'h0, "no_irq_bits");
`endif

    // Out-of-range index on the 3-mutex bank
    wr(1, 3'd6, 32'h0001_0001);
    rd(1, 3'd6, 32'h0, "oor_mutex");
    wr(1, 3'd7, 32'h1);
    rd(1, 3'd7, 32'h0, "oor_status");
    rd(1, 3'd1, 32'h3, "oor_init_kept");

    // Reset mid-lease discards everything
    wr(1, 3'd2, 32'h0002_0009);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    rd(1, 3'd2, 32'h0, "rst_mid_val");
    rd(1, 3'd3, 32'h1, "rst_mid_status");
    rd(1, 3'd1, 32'h1, "rst_mid_status0");
    rd(1, 3'd4, 32'h0, "rst_mid_mutex2");
    idle(10);
    rd(1, 3'd3, 32'h1, "rst_no_late_expiry");

    idle(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
